// File: rtl/prores_pkg.sv
// Shared types for the size-patch write-back path: request struct, FSM states, byte select.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package prores_pkg;

    localparam int MAX_PATCH_BYTES = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] val;
        logic [2:0]  size;
    } patch_req_t;

    // Byte k of an n-byte big-endian field; bits above n*8 never reach the output.
    function automatic logic [7:0] patch_byte(input logic [31:0] v,
                                              input logic [2:0]  n,
                                              input logic [2:0]  k);
        logic [1:0] sel;
        sel = 2'(n - k - 3'd1);
        return 8'(v >> {sel, 3'b000});
    endfunction

endpackage

// File: rtl/patch_fifo.sv
// Synchronous request FIFO of patch_req_t entries with occupancy count.
// Latency: pushed entry visible at pop_dat one cycle after the push edge.
// Backpressure: push while full is accepted only alongside a pop; otherwise ignored.
module patch_fifo
    import prores_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  patch_req_t               push_dat,
    input  logic                     pop,
    output patch_req_t               pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    patch_req_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/size_patch_writer.sv
// Queues size-patch requests and writes each field big-endian, one byte per cycle.
// Latency: first byte strobed one cycle after the request edge when idle; n cycles per n-byte field.
// Backpressure: none upstream; a valid request meeting a full FIFO with no pop is dropped and flagged.
module size_patch_writer
    import prores_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       offset_addr,
    input  logic [31:0]       val,
    input  logic [31:0]       byte_size,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              overflow,
    output logic              bad_size
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t      state_q, state_d;
    patch_req_t  req, head, cur_q, cur_d, src;
    logic [2:0]  idx_q, idx_d, k;
    logic [CW-1:0] count;
    logic        req_vld, req_bad, push_acc;
    logic        full, empty, pop, emit, last, nonempty_d;

    assign req_vld  = (byte_size != 32'd0) && (byte_size <= 32'(MAX_PATCH_BYTES));
    assign req_bad  = (byte_size > 32'(MAX_PATCH_BYTES));
    assign req      = '{addr: offset_addr, val: val, size: byte_size[2:0]};
    assign push_acc = req_vld && (!full || pop);
    assign last     = (idx_q == cur_q.size - 3'd1);

    patch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (req_vld),
        .push_dat (req),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty && head.size != 3'd1) state_d = WRITE;
            WRITE:   if (last && empty)               state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Popping on the final byte lets the next field's byte 0 follow without a bubble.
    always_comb begin
        pop   = 1'b0;
        emit  = 1'b0;
        src   = cur_q;
        k     = idx_q;
        cur_d = cur_q;
        idx_d = idx_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    emit  = 1'b1;
                    src   = head;
                    k     = 3'd0;
                    cur_d = head;
                    idx_d = 3'd1;
                end
            end
            WRITE: begin
                emit = 1'b1;
                if (!last) begin
                    idx_d = idx_q + 3'd1;
                end else if (!empty) begin
                    pop   = 1'b1;
                    cur_d = head;
                    idx_d = 3'd0;
                end
            end
            default: ;
        endcase
    end

    assign nonempty_d = push_acc || (!empty && !(pop && count == CW'(1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            bad_size <= 1'b0;
            cur_q    <= '0;
            idx_q    <= '0;
        end else begin
            wr_en <= emit;
            if (emit) begin
                wr_addr <= ADDR_W'(src.addr + 32'(k));
                wr_data <= patch_byte(src.val, src.size, k);
            end
            busy     <= nonempty_d || (state_d == WRITE) || emit;
            overflow <= overflow | (req_vld & ~push_acc);
            bad_size <= bad_size | req_bad;
            cur_q    <= cur_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_size_patch_writer.sv
// Scoreboard bench for size_patch_writer: DEPTH=8 main instance plus a DEPTH=2 instance
// sharing the same stimulus, used only for the overflow scenario.
module tb_size_patch_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] offset_addr = '0;
    logic [31:0] val = '0;
    logic [31:0] byte_size = '0;

    logic        en1, busy1, ovf1, bad1;
    logic [12:0] a1;
    logic [7:0]  d1;
    logic        en2, busy2, ovf2, bad2;
    logic [12:0] a2;
    logic [7:0]  d2;

    typedef struct {
        int          cyc;
        logic [12:0] addr;
        logic [7:0]  data;
    } obs_t;

    logic [20:0] exp_q[$];
    obs_t        obs_q[$];
    bit          busy_log[int];
    int          cyc = 0;
    int          tests = 0;
    int          failed = 0;

    size_patch_writer #(.DEPTH(8), .ADDR_W(13)) dut (
        .clock(clock), .reset(reset), .offset_addr(offset_addr), .val(val),
        .byte_size(byte_size), .wr_en(en1), .wr_addr(a1), .wr_data(d1),
        .busy(busy1), .overflow(ovf1), .bad_size(bad1)
    );

    size_patch_writer #(.DEPTH(2), .ADDR_W(13)) dut2 (
        .clock(clock), .reset(reset), .offset_addr(offset_addr), .val(val),
        .byte_size(byte_size), .wr_en(en2), .wr_addr(a2), .wr_data(d2),
        .busy(busy2), .overflow(ovf2), .bad_size(bad2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        byte_size = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        exp_q.delete();
        obs_q.delete();
        busy_log.delete();
    endtask

    // Drives one request; it is sampled on the next rising edge, and the task returns 1 time unit after it.
    task automatic send(input logic [31:0] off, input logic [31:0] v, input logic [31:0] sz);
        offset_addr = off;
        val         = v;
        byte_size   = sz;
        @(posedge clock);
        #1;
        byte_size = '0;
    endtask

    task automatic expect_req(input logic [31:0] off, input logic [31:0] v, input int n);
        for (int kk = 0; kk < n; kk++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = off + 32'(kk);
            d = v >> (8 * (n - 1 - kk));
            exp_q.push_back({a[12:0], d[7:0]});
        end
    endtask

    task automatic capture(input int n, input bit sel2);
        for (int i = 0; i < n; i++) begin
            obs_t o;
            @(negedge clock);
            busy_log[cyc] = sel2 ? busy2 : busy1;
            if (sel2 ? en2 : en1) begin
                o.cyc  = cyc;
                o.addr = sel2 ? a2 : a1;
                o.data = sel2 ? d2 : d1;
                obs_q.push_back(o);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (en1 !== 1'b0)     begin failed++; $display("FAIL reset_wr_en: got %b want 0", en1); end
        tests++; if (a1 !== 13'h0)     begin failed++; $display("FAIL reset_wr_addr: got %h want 0", a1); end
        tests++; if (d1 !== 8'h0)      begin failed++; $display("FAIL reset_wr_data: got %h want 0", d1); end
        tests++; if (busy1 !== 1'b0)   begin failed++; $display("FAIL reset_busy: got %b want 0", busy1); end
        tests++; if (ovf1 !== 1'b0)    begin failed++; $display("FAIL reset_overflow: got %b want 0", ovf1); end
        tests++; if (bad1 !== 1'b0)    begin failed++; $display("FAIL reset_bad_size: got %b want 0", bad1); end
    endtask

    task automatic test_two_byte();
        int pc;
        logic [20:0] e;
        obs_t o;
        do_reset();
        expect_req(32'h010, 32'h1234, 2);
        send(32'h010, 32'h1234, 32'd2);
        pc = cyc;
        tests++; if (busy1 !== 1'b1) begin failed++; $display("FAIL two_busy_rise: got %b want 1", busy1); end
        capture(6, 1'b0);
        tests++;
        if (obs_q.size() == 0 || obs_q[0].cyc != pc + 1) begin
            failed++; $display("FAIL two_latency: first write cycle %0d want %0d", obs_q.size() ? obs_q[0].cyc : -1, pc + 1);
        end
        tests++; if (busy_log[pc + 2] !== 1'b1) begin failed++; $display("FAIL two_busy_final: got %b want 1", busy_log[pc + 2]); end
        tests++; if (busy_log[pc + 3] !== 1'b0) begin failed++; $display("FAIL two_busy_fall: got %b want 0", busy_log[pc + 3]); end
        tests++;
        if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL two_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL two_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
    endtask

    task automatic test_four_and_mask();
        logic [20:0] e;
        obs_t o;
        do_reset();
        expect_req(32'h008, 32'h000A0B0C, 4);
        expect_req(32'h040, 32'hFFFFFF5A, 1);
        send(32'h008, 32'h000A0B0C, 32'd4);
        send(32'h040, 32'hFFFFFF5A, 32'd1);
        capture(10, 1'b0);
        tests++;
        if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL four_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL four_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int pc;
        logic [20:0] e;
        obs_t o;
        logic [31:0] offs [5] = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h140};
        logic [31:0] vals [5] = '{32'hA1A2, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2, 32'hE1E2};
        int          szs  [5] = '{2, 4, 4, 2, 2};
        do_reset();
        for (int i = 0; i < 5; i++) expect_req(offs[i], vals[i], szs[i]);
        pc = cyc + 1;
        fork
            for (int i = 0; i < 5; i++) send(offs[i], vals[i], 32'(szs[i]));
            capture(24, 1'b0);
        join
        tests++;
        if (obs_q.size() != 14) begin failed++; $display("FAIL burst_count: got %0d writes want 14", obs_q.size()); end
        tests++;
        if (obs_q.size() < 14 || obs_q[0].cyc != pc + 1 || obs_q[13].cyc != pc + 14) begin
            failed++; $display("FAIL burst_contiguous: span %0d..%0d want %0d..%0d",
                obs_q.size() ? obs_q[0].cyc : -1, obs_q.size() ? obs_q[obs_q.size()-1].cyc : -1, pc + 1, pc + 14);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL burst_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
        tests++; if (ovf1 !== 1'b0) begin failed++; $display("FAIL burst_overflow: got %b want 0", ovf1); end
    endtask

    // DEPTH=2: r3 arrives with two entries queued and no pop, r4 coincides with a pop, r5 finds it full again.
    task automatic test_overflow();
        logic [20:0] e;
        obs_t o;
        do_reset();
        expect_req(32'h200, 32'h10203040, 4);
        expect_req(32'h210, 32'h11213141, 4);
        expect_req(32'h220, 32'h12223242, 4);
        expect_req(32'h240, 32'h14243444, 4);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'h200 + 32'(16 * i), 32'h10203040 + 32'h01010101 * 32'(i), 32'd4);
                    if (i == 2) begin
                        tests++; if (ovf2 !== 1'b0) begin failed++; $display("FAIL ovf_early: got %b want 0", ovf2); end
                    end
                    if (i == 3) begin
                        tests++; if (ovf2 !== 1'b1) begin failed++; $display("FAIL ovf_set: got %b want 1", ovf2); end
                    end
                end
            end
            capture(30, 1'b1);
        join
        tests++;
        if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL ovf_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL ovf_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
        tests++; if (ovf2 !== 1'b1)  begin failed++; $display("FAIL ovf_sticky: got %b want 1", ovf2); end
        tests++; if (busy2 !== 1'b0) begin failed++; $display("FAIL ovf_busy_end: got %b want 0", busy2); end
    endtask

    task automatic test_bad_size();
        logic [20:0] e;
        obs_t o;
        do_reset();
        send(32'h020, 32'h55, 32'd5);
        tests++; if (bad1 !== 1'b1) begin failed++; $display("FAIL bad_set: got %b want 1", bad1); end
        capture(4, 1'b0);
        tests++; if (obs_q.size() != 0) begin failed++; $display("FAIL bad_no_write: got %0d writes want 0", obs_q.size()); end
        obs_q.delete();
        expect_req(32'h030, 32'h00A1B2C3, 3);
        send(32'h030, 32'h00A1B2C3, 32'd3);
        capture(8, 1'b0);
        tests++;
        if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL bad_follow_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL bad_follow_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
        tests++; if (bad1 !== 1'b1) begin failed++; $display("FAIL bad_sticky: got %b want 1", bad1); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(32'h300, 32'h01020304, 32'd4);
        send(32'h310, 32'h05060708, 32'd4);
        send(32'h320, 32'h090A0B0C, 32'd4);
        @(posedge clock);
        #1;
        tests++;
        if (en1 !== 1'b1 || a1 !== 13'h302 || d1 !== 8'h03) begin
            failed++; $display("FAIL mid_byte2: got %b/%h/%h want 1/0302/03", en1, a1, d1);
        end
        reset = 1'b1;
        #1;
        tests++; if (en1 !== 1'b0)   begin failed++; $display("FAIL mid_async_wr_en: got %b want 0", en1); end
        tests++; if (busy1 !== 1'b0) begin failed++; $display("FAIL mid_async_busy: got %b want 0", busy1); end
        @(negedge clock);
        reset = 1'b0;
        obs_q.delete();
        capture(12, 1'b0);
        tests++; if (obs_q.size() != 0) begin failed++; $display("FAIL mid_no_writes: got %0d writes want 0", obs_q.size()); end
        tests++; if (busy1 !== 1'b0)    begin failed++; $display("FAIL mid_idle_busy: got %b want 0", busy1); end
    endtask

    task automatic test_wrap();
        logic [20:0] e;
        obs_t o;
        do_reset();
        expect_req(32'h1FFF, 32'hBEEF, 2);
        send(32'h1FFF, 32'hBEEF, 32'd2);
        capture(6, 1'b0);
        tests++;
        if (obs_q.size() != exp_q.size()) begin failed++; $display("FAIL wrap_count: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++; if ({o.addr, o.data} !== e) begin failed++; $display("FAIL wrap_byte: got %h/%h want %h/%h", o.addr, o.data, e[20:8], e[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_four_and_mask();
        test_back_to_back();
        test_overflow();
        test_bad_size();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
